candy_issue_ctrl: RTL and testbench

//  Issue/hazard controller between candy_id and execute. Holds one decoded instruction in an

---
 rtl/candy_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_candy_issue_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/candy_issue_ctrl.sv
// Issue slot + per-register pending-write scoreboard between candy_id and execute.
// Optional macro CANDY_WB_BYPASS_EN: hazard check and sb_empty see the post-writeback count.
module candy_issue_ctrl #(
  parameter int NREG   = 16,
  parameter int RA_W   = 4,
  parameter int OP_W   = 6,
  parameter int IMM_W  = 16,
  parameter int PEND_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [1:0]       dec_type,
  input  logic [OP_W-1:0]  dec_op,
  input  logic [RA_W-1:0]  dec_rs1,
  input  logic [RA_W-1:0]  dec_rs2,
  input  logic [RA_W-1:0]  dec_rd,
  input  logic [IMM_W-1:0] dec_imm,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [OP_W-1:0]  iss_op,
  output logic [RA_W-1:0]  iss_rs1,
  output logic [RA_W-1:0]  iss_rs2,
  output logic [RA_W-1:0]  iss_rd,
  output logic [IMM_W-1:0] iss_imm,
  output logic             iss_wen,
  input  logic             wb_valid,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic             sb_empty
);

  typedef enum logic [1:0] {T_R = 2'd0, T_I = 2'd1, T_S = 2'd2, T_U = 2'd3} itype_e;
  typedef enum logic {RUN, DRAIN} state_e;

  state_e            state;
  logic [PEND_W-1:0] pend     [NREG];
  logic [PEND_W-1:0] pend_eff [NREG];
  logic [PEND_W-1:0] pend_nxt [NREG];

  logic reads1, reads2, writes, dec_wen;
  logic hit_rs1, hit_rs2, hit_rd;
  logic haz_rs1, haz_rs2, haz_rd, hazard;
  logic accept, issue_hs, inc;
  logic empty_nxt, empty_eff;

  // Counts seen by the hazard check; with bypass a same-cycle writeback already counts.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      pend_eff[i] = pend[i];
`ifdef CANDY_WB_BYPASS_EN
      if (wb_valid && wb_rd == RA_W'(i) && pend[i] != '0)
        pend_eff[i] = pend[i] - PEND_W'(1);
`endif
    end
  end

  always_comb begin
    reads1  = (dec_type != T_U);
    reads2  = (dec_type == T_R) || (dec_type == T_S);
    writes  = (dec_type != T_S);
    dec_wen = writes && (dec_rd != '0);

    hit_rs1 = iss_valid && iss_wen && (iss_rd == dec_rs1);
    hit_rs2 = iss_valid && iss_wen && (iss_rd == dec_rs2);
    hit_rd  = iss_valid && iss_wen && (iss_rd == dec_rd);

    haz_rs1 = reads1 && (dec_rs1 != '0) && ((pend_eff[dec_rs1] != '0) || hit_rs1);
    haz_rs2 = reads2 && (dec_rs2 != '0) && ((pend_eff[dec_rs2] != '0) || hit_rs2);
    haz_rd  = dec_wen && ((pend_eff[dec_rd] == '1) || hit_rd);
    hazard  = haz_rs1 || haz_rs2 || haz_rd;

    dec_ready = (state == RUN) && !hazard && (!iss_valid || iss_ready) && !flush;
    stall     = dec_valid && !dec_ready;
    accept    = dec_valid && dec_ready;
    issue_hs  = iss_valid && iss_ready && !flush;
    inc       = issue_hs && iss_wen;
  end

  // Increment from issue and decrement from writeback cancel on the same register.
  always_comb begin
    empty_nxt = 1'b1;
    empty_eff = 1'b1;
    for (int unsigned i = 0; i < NREG; i++) begin
      logic inc_i, dec_i;
      inc_i = inc && (iss_rd == RA_W'(i));
      dec_i = wb_valid && (wb_rd == RA_W'(i)) && (pend[i] != '0);
      pend_nxt[i] = pend[i];
      if (inc_i && !dec_i)
        pend_nxt[i] = pend[i] + PEND_W'(1);
      else if (dec_i && !inc_i)
        pend_nxt[i] = pend[i] - PEND_W'(1);
      if (pend_nxt[i] != '0) empty_nxt = 1'b0;
      if (pend_eff[i] != '0) empty_eff = 1'b0;
    end
  end

`ifdef CANDY_WB_BYPASS_EN
  logic unused_empty;
  assign unused_empty = empty_nxt;
  assign sb_empty     = empty_eff;
`else
  logic sb_empty_q;
  logic unused_empty;
  assign unused_empty = empty_eff;
  assign sb_empty     = sb_empty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_empty_q <= 1'b1;
    else     sb_empty_q <= empty_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_imm   <= '0;
      iss_wen   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) pend[i] <= pend_nxt[i];

      case (state)
        RUN:     if (flush) state <= DRAIN;
        DRAIN:   if (!flush && sb_empty) state <= RUN;
        default: state <= RUN;
      endcase

      if (accept) begin
        iss_valid <= 1'b1;
        iss_op    <= dec_op;
        iss_rs1   <= dec_rs1;
        iss_rs2   <= dec_rs2;
        iss_rd    <= dec_rd;
        iss_imm   <= dec_imm;
        iss_wen   <= dec_wen;
      end else if (issue_hs || flush) begin
        iss_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_candy_issue_ctrl.sv
// Randomized bench for candy_issue_ctrl against an integer-count reference model.
module tb_candy_issue_ctrl;
  localparam int NREG = 16, RA_W = 4, OP_W = 6, IMM_W = 16, PEND_W = 2;
  localparam int PMAX = (1 << PEND_W) - 1;
  localparam logic [1:0] TR = 2'd0, TI = 2'd1, TS = 2'd2, TU = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_ready;
  logic [1:0] dec_type;
  logic [OP_W-1:0] dec_op;
  logic [RA_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [IMM_W-1:0] dec_imm;
  logic iss_valid, iss_ready;
  logic [OP_W-1:0] iss_op;
  logic [RA_W-1:0] iss_rs1, iss_rs2, iss_rd;
  logic [IMM_W-1:0] iss_imm;
  logic iss_wen;
  logic wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic flush, stall, sb_empty;

  always #5 clk = ~clk;

  candy_issue_ctrl #(.NREG(NREG), .RA_W(RA_W), .OP_W(OP_W), .IMM_W(IMM_W), .PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_type(dec_type), .dec_op(dec_op),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_imm(dec_imm),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_imm(iss_imm), .iss_wen(iss_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall), .sb_empty(sb_empty)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending writes per register, one slot, a drain flag.
  int pend [NREG];
  bit m_v, m_wen, m_drain, m_sbe;
  logic [OP_W-1:0] m_op;
  logic [RA_W-1:0] m_rs1, m_rs2, m_rd;
  logic [IMM_W-1:0] m_imm;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    m_v = 0; m_wen = 0; m_drain = 0; m_sbe = 1;
    m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0;
  endtask

  function automatic int cnt(int r);
    int c = pend[r];
`ifdef CANDY_WB_BYPASS_EN
    if (wb_valid && int'(wb_rd) == r && c > 0) c--;
`endif
    return c;
  endfunction

  function automatic bit slot_writes(int r);
    return m_v && m_wen && int'(m_rd) == r;
  endfunction

  function automatic bit busy(int r);
    return r != 0 && (cnt(r) > 0 || slot_writes(r));
  endfunction

  // Called at a negedge with inputs already driven; checks, then advances the model.
  task automatic cycle();
    bit r1, r2, wen, haz, er, hs, sbe;
    #1;
    r1  = dec_type != TU;
    r2  = dec_type == TR || dec_type == TS;
    wen = dec_type != TS && dec_rd != 0;
    haz = (r1 && busy(int'(dec_rs1))) || (r2 && busy(int'(dec_rs2))) ||
          (wen && (cnt(int'(dec_rd)) == PMAX || slot_writes(int'(dec_rd))));
    er  = !m_drain && !haz && (!m_v || iss_ready) && !flush;
`ifdef CANDY_WB_BYPASS_EN
    sbe = 1;
    for (int i = 0; i < NREG; i++) if (cnt(i) != 0) sbe = 0;
`else
    sbe = m_sbe;
`endif
    check("dec_ready", dec_ready, er);
    check("stall", stall, dec_valid && !er);
    check("iss_valid", iss_valid, m_v);
    if (m_v)
      check("slot", {iss_op, iss_rs1, iss_rs2, iss_rd, iss_imm, iss_wen},
                    {m_op, m_rs1, m_rs2, m_rd, m_imm, m_wen});
    check("sb_empty", sb_empty, sbe);

    hs = m_v && iss_ready && !flush;
    if (wb_valid && pend[int'(wb_rd)] > 0) pend[int'(wb_rd)]--;
    if (hs && m_wen) pend[int'(m_rd)]++;
    if (flush) m_drain = 1;
    else if (m_drain && sbe) m_drain = 0;
    if (dec_valid && er) begin
      m_v = 1; m_wen = wen; m_op = dec_op; m_rs1 = dec_rs1; m_rs2 = dec_rs2;
      m_rd = dec_rd; m_imm = dec_imm;
    end else if (hs || flush) begin
      m_v = 0;
    end
    m_sbe = 1;
    foreach (pend[i]) if (pend[i] != 0) m_sbe = 0;
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] t, input int s1, input int s2, input int d,
                       input bit ir, input bit wv, input int wr, input bit fl);
    dec_valid = v; dec_type = t;
    dec_rs1 = RA_W'(s1); dec_rs2 = RA_W'(s2); dec_rd = RA_W'(d);
    dec_op = OP_W'($urandom); dec_imm = IMM_W'($urandom_range(0, 1023));
    iss_ready = ir; wb_valid = wv; wb_rd = RA_W'(wr); flush = fl;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1; dec_valid = 0; flush = 0; wb_valid = 0; iss_ready = 0;
    #1;
    model_reset();
    check("rst_iss_valid", iss_valid, 1'b0);
    check("rst_slot", {iss_op, iss_rs1, iss_rs2, iss_rd, iss_imm, iss_wen}, 64'd0);
    check("rst_sb_empty", sb_empty, 1'b1);
    check("rst_dec_ready", dec_ready, 1'b1);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 0; dec_valid = 0; dec_type = TR; dec_op = '0; dec_rs1 = '0; dec_rs2 = '0;
    dec_rd = '0; dec_imm = '0; iss_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    @(negedge clk);
    do_reset();

    // R r1=r2+r3 through to issue
    drive(1, TR, 2, 3, 1, 1, 0, 0, 0);
    drive(0, TR, 0, 0, 0, 1, 0, 0, 0);
    drive(0, TR, 0, 0, 0, 1, 0, 0, 0);
    // RAW on r5 released by writeback
    drive(1, TR, 0, 0, 5, 1, 0, 0, 0);
    repeat (3) drive(1, TI, 5, 0, 6, 1, 0, 0, 0);
    drive(1, TI, 5, 0, 6, 1, 1, 5, 0);
    repeat (2) drive(1, TI, 5, 0, 6, 1, 0, 0, 0);
    // Saturating pending count on r7
    repeat (10) drive(1, TU, 0, 0, 7, 1, 0, 0, 0);
    drive(1, TU, 0, 0, 7, 1, 1, 7, 0);
    repeat (3) drive(1, TU, 0, 0, 7, 1, 0, 0, 0);
    // Back-pressure, S op writes nothing so busy r9 is no hazard
    drive(1, TU, 0, 0, 9, 1, 0, 0, 0);
    drive(1, TU, 0, 0, 8, 0, 0, 0, 0);
    repeat (4) drive(1, TS, 1, 2, 9, 0, 0, 0, 0);
    drive(1, TS, 3, 0, 9, 1, 0, 0, 0);
    // Flush with slot valid, drain until writebacks arrive
    drive(1, TR, 0, 0, 2, 1, 0, 0, 0);
    drive(1, TI, 0, 0, 4, 0, 0, 0, 0);
    drive(0, TR, 0, 0, 0, 1, 0, 0, 1);
    for (int r = 0; r < NREG; r++) begin
      drive(1, TR, 0, 0, 3, 1, 1, r, 0);
      drive(1, TR, 0, 0, 3, 1, 1, r, 0);
      drive(1, TR, 0, 0, 3, 1, 1, r, 0);
    end
    repeat (3) drive(0, TR, 0, 0, 0, 1, 0, 0, 0);
    // Same-cycle inc and dec on r4, writeback to r0 and idle register
    drive(1, TU, 0, 0, 4, 1, 0, 0, 0);
    drive(0, TU, 0, 0, 0, 1, 0, 0, 0);
    drive(1, TU, 0, 0, 4, 1, 0, 0, 0);
    drive(0, TU, 0, 0, 0, 1, 1, 4, 0);
    drive(0, TU, 0, 0, 0, 1, 1, 0, 0);
    drive(0, TU, 0, 0, 0, 1, 1, 11, 0);
    // Reset in the middle of a drain
    drive(0, TU, 0, 0, 0, 1, 0, 0, 1);
    drive(0, TU, 0, 0, 0, 1, 0, 0, 0);
    do_reset();
    drive(0, TU, 0, 0, 0, 1, 1, 4, 0);
    drive(1, TR, 4, 4, 4, 1, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 300 == 0) do_reset();
      drive(($urandom % 4) != 0, 2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), ($urandom % 4) != 0, ($urandom % 3) == 0,
            $urandom_range(0, 7), ($urandom % 40) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
